// File: rtl/cmd_phys_layer_if.sv
// CMD_master <-> CMD physical layer handshake bundle: command REQ/ACK pair
// and response REQ/ACK pair, both 4-phase.
interface cmd_phys_layer_if;
  // 4-phase handshake: the requester raises REQ with its data held stable, the
  // responder raises ACK, the requester drops REQ, the responder drops ACK.
  logic [37:0] cmd_to_send;
  logic        REQ_in;
  logic        ACK_out;
  logic [37:0] response;
  logic        REQ_out;
  logic        ACK_in;
  logic        crc_error;
  logic        timeout_error;

  modport master (
    output cmd_to_send, REQ_in, ACK_in,
    input  ACK_out, response, REQ_out, crc_error, timeout_error
  );

  modport slave (
    input  cmd_to_send, REQ_in, ACK_in,
    output ACK_out, response, REQ_out, crc_error, timeout_error
  );
endinterface

// File: rtl/cmd_phys_layer.sv
// SD-host CMD-line physical layer: frames/serialises commands, captures and checks responses.
// Define CMD_CRC_CHECK_EN to add the received-CRC7 check to crc_error.
module cmd_phys_layer #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic               CLK_host,
  input  logic               reset,
  cmd_phys_layer_if.slave    bus,
  output logic               cmd_out_sd,
  output logic               cmd_oe,
  input  logic               cmd_in_sd,
  output logic [2:0]         state_dbg
);

  localparam int CNT_MAX = (RESP_TIMEOUT > 48) ? RESP_TIMEOUT : 48;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK_WAIT  = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4,
    CHECK     = 3'd5,
    RESP_REQ  = 3'd6,
    RESP_REL  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [37:0]        cmd_q, cmd_d;
  logic [46:0]        tx_q, tx_d;
  logic [46:0]        rx_q, rx_d;
  logic [37:0]        resp_q, resp_d;
  logic               ack_q, ack_d;
  logic               req_q, req_d;
  logic               crc_err_q, crc_err_d;
  logic               to_err_q, to_err_d;
  logic               oe_q, oe_d;
  logic               out_q, out_d;
  logic [47:0]        frame;
  logic               rx_bad;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign frame = {2'b01, cmd_q, crc7({2'b01, cmd_q}), 1'b1};

  // rx_q holds frame bits 46..0; the start bit is implied and never stored.
`ifdef CMD_CRC_CHECK_EN
  assign rx_bad = rx_q[46] | ~rx_q[0] | (crc7({1'b0, rx_q[46:8]}) != rx_q[7:1]);
`else
  assign rx_bad = rx_q[46] | ~rx_q[0];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    ack_d     = ack_q;
    req_d     = req_q;
    crc_err_d = crc_err_q;
    to_err_d  = to_err_q;
    oe_d      = oe_q;
    out_d     = out_q;
    case (state_q)
      IDLE: if (bus.REQ_in) begin
        cmd_d     = bus.cmd_to_send;
        crc_err_d = 1'b0;
        to_err_d  = 1'b0;
        ack_d     = 1'b1;
        state_d   = ACK_WAIT;
      end
      ACK_WAIT: if (!bus.REQ_in) begin
        ack_d   = 1'b0;
        tx_d    = frame[46:0];
        out_d   = frame[47];
        oe_d    = 1'b1;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (cnt_q == CNT_W'(47)) begin
        oe_d    = 1'b0;
        out_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_RESP;
      end else begin
        out_d = tx_q[46];
        tx_d  = {tx_q[45:0], 1'b1};
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Start bit is tested before the timeout so a late start bit still wins.
      WAIT_RESP: if (!cmd_in_sd) begin
        cnt_d   = CNT_W'(1);
        state_d = RECV;
      end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
        to_err_d = 1'b1;
        resp_d   = '0;
        req_d    = 1'b1;
        cnt_d    = '0;
        state_d  = RESP_REQ;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      RECV: begin
        rx_d = {rx_q[45:0], cmd_in_sd};
        if (cnt_q == CNT_W'(47)) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        resp_d    = rx_q[45:8];
        crc_err_d = rx_bad;
        req_d     = 1'b1;
        state_d   = RESP_REQ;
      end
      RESP_REQ: if (bus.ACK_in) begin
        req_d   = 1'b0;
        state_d = RESP_REL;
      end
      RESP_REL: if (!bus.ACK_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      resp_q    <= '0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      crc_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      crc_err_q <= crc_err_d;
      to_err_q  <= to_err_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  assign bus.ACK_out       = ack_q;
  assign bus.REQ_out       = req_q;
  assign bus.response      = resp_q;
  assign bus.crc_error     = crc_err_q;
  assign bus.timeout_error = to_err_q;
  assign cmd_out_sd        = out_q;
  assign cmd_oe            = oe_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_cmd_phys_layer.sv
// Directed self-checking bench for cmd_phys_layer: command framing, response
// capture, error flags, handshake stalls and mid-transfer reset.
module tb_cmd_phys_layer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_out_sd, cmd_oe, cmd_in_sd;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  localparam logic [2:0]  S_IDLE = 3'd0, S_RESP_REL = 3'd7;
  localparam logic [47:0] TX_CMD0   = 48'h40_0000_0000_95;
  localparam logic [47:0] TX_CMD8   = 48'h48_0000_01AA_87;
  localparam logic [47:0] R8_GOOD   = 48'h08_0000_01AA_13;
  localparam logic [47:0] R8_BADCRC = 48'h08_0000_01AA_15;
  localparam logic [47:0] R8_BADEND = 48'h08_0000_01AA_12;
  localparam logic [47:0] R8_BADTX  = 48'h48_0000_01AA_13;
  localparam logic [37:0] CMD8      = {6'd8, 32'h0000_01AA};
  localparam logic [37:0] RESP8     = {6'd8, 32'h0000_01AA};

  always #5 clk = ~clk;

  cmd_phys_layer_if bus();

  cmd_phys_layer #(.RESP_TIMEOUT(64)) dut (
    .CLK_host   (clk),
    .reset      (reset),
    .bus        (bus),
    .cmd_out_sd (cmd_out_sd),
    .cmd_oe     (cmd_oe),
    .cmd_in_sd  (cmd_in_sd),
    .state_dbg  (state_dbg)
  );

  // Driver: full command handshake, serial capture, then card model driving
  // resp starting d cycles into WAIT_RESP. lat = cycles from WAIT_RESP start to REQ_out.
  task automatic run_cmd(input logic [37:0] cmd, input bit resp_en, input logic [47:0] resp,
                         input int d, output logic [47:0] tx, output int oe_cnt,
                         output int lat, output bit hs_ok);
    int n;
    int idx;
    hs_ok  = 1'b1;
    tx     = '0;
    oe_cnt = 0;
    lat    = -1;
    @(negedge clk);
    bus.cmd_to_send = cmd;
    bus.REQ_in      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ACK_out && n < 10);
    if (!bus.ACK_out) hs_ok = 1'b0;
    bus.REQ_in = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (cmd_oe) begin
        tx = {tx[46:0], cmd_out_sd};
        oe_cnt++;
        if (bus.ACK_out) hs_ok = 1'b0;
      end else if (oe_cnt > 0) begin
        break;
      end
    end
    if (cmd_out_sd !== 1'b1) hs_ok = 1'b0;
    n = 0;
    while (n < 300) begin
      if (bus.REQ_out) break;
      idx = 47 - (n - d);
      cmd_in_sd = (resp_en && n >= d && n < d + 48) ? resp[idx] : 1'b1;
      @(negedge clk);
      n++;
    end
    cmd_in_sd = 1'b1;
    if (bus.REQ_out) lat = n;
  endtask

  // Driver: completes the response handshake and reports what it observed.
  task automatic release_resp(output bit req_dropped, output bit back_idle);
    bus.ACK_in = 1'b1;
    @(negedge clk);
    req_dropped = (bus.REQ_out === 1'b0) && (state_dbg === S_RESP_REL);
    bus.ACK_in = 1'b0;
    @(negedge clk);
    back_idle = (state_dbg === S_IDLE);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.REQ_in = 1'b0;
    bus.ACK_in = 1'b0;
    bus.cmd_to_send = '0;
    cmd_in_sd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ACK_out, bus.REQ_out, bus.crc_error, bus.timeout_error, cmd_out_sd, cmd_oe} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000010",
               {bus.ACK_out, bus.REQ_out, bus.crc_error, bus.timeout_error, cmd_out_sd, cmd_oe});
    end
    checks++;
    if (bus.response !== 38'h0) begin
      errors++;
      $display("FAIL reset_response: got %h expected 0", bus.response);
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One response scenario: command, card answer after d cycles, expected flags.
  task automatic test_response(input string name, input logic [37:0] cmd, input logic [47:0] exp_tx,
                               input bit resp_en, input logic [47:0] resp, input int d,
                               input int exp_lat, input logic [37:0] exp_resp,
                               input logic exp_crc, input logic exp_to);
    logic [47:0] tx;
    int oe_cnt, lat;
    bit hs_ok, req_dropped, back_idle;
    run_cmd(cmd, resp_en, resp, d, tx, oe_cnt, lat, hs_ok);
    checks++;
    if (tx !== exp_tx) begin
      errors++;
      $display("FAIL %s tx_frame: got %h expected %h", name, tx, exp_tx);
    end
    checks++;
    if (oe_cnt !== 48 || !hs_ok) begin
      errors++;
      $display("FAIL %s oe_len/handshake: got oe=%0d hs=%0d expected oe=48 hs=1", name, oe_cnt, hs_ok);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s req_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.response !== exp_resp) begin
      errors++;
      $display("FAIL %s response: got %h expected %h", name, bus.response, exp_resp);
    end
    checks++;
    if ({bus.crc_error, bus.timeout_error} !== {exp_crc, exp_to}) begin
      errors++;
      $display("FAIL %s crc/timeout: got %b expected %b", name,
               {bus.crc_error, bus.timeout_error}, {exp_crc, exp_to});
    end
    release_resp(req_dropped, back_idle);
    checks++;
    if (!req_dropped || !back_idle) begin
      errors++;
      $display("FAIL %s release: got drop=%0d idle=%0d expected 1 1", name, req_dropped, back_idle);
    end
  endtask

  task automatic test_handshake_stall();
    logic [47:0] tx;
    int oe_cnt, lat;
    bit hs_ok, stall_ok, ack_quiet;
    run_cmd(CMD8, 1'b1, R8_GOOD, 5, tx, oe_cnt, lat, hs_ok);
    checks++;
    if (lat !== 54 || bus.response !== RESP8) begin
      errors++;
      $display("FAIL stall_setup: got lat=%0d resp=%h expected 54 %h", lat, bus.response, RESP8);
    end
    stall_ok  = 1'b1;
    ack_quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.REQ_in = (i >= 5 && i < 8);
      bus.cmd_to_send = {6'd17, 32'hDEAD_BEEF};
      @(negedge clk);
      if (bus.REQ_out !== 1'b1 || bus.response !== RESP8) stall_ok = 1'b0;
      if (bus.ACK_out !== 1'b0) ack_quiet = 1'b0;
    end
    bus.REQ_in = 1'b0;
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL stall_hold: got REQ_out=%b resp=%h expected 1 %h", bus.REQ_out, bus.response, RESP8);
    end
    checks++;
    if (!ack_quiet) begin
      errors++;
      $display("FAIL stall_req_in_ignored: got ACK_out pulse expected none");
    end
    bus.ACK_in = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.REQ_out !== 1'b0 || state_dbg !== S_RESP_REL) begin
      errors++;
      $display("FAIL stall_ack: got REQ_out=%b state=%0d expected 0 %0d", bus.REQ_out, state_dbg, S_RESP_REL);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== S_RESP_REL) begin
      errors++;
      $display("FAIL stall_ack_held: got state=%0d expected %0d", state_dbg, S_RESP_REL);
    end
    bus.ACK_in = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== S_IDLE || bus.response !== RESP8) begin
      errors++;
      $display("FAIL stall_idle: got state=%0d resp=%h expected %0d %h", state_dbg, bus.response, S_IDLE, RESP8);
    end
  endtask

  task automatic test_reset_mid_send();
    int n, bits;
    @(negedge clk);
    bus.cmd_to_send = CMD8;
    bus.REQ_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ACK_out && n < 10);
    bus.REQ_in = 1'b0;
    bits = 0;
    n = 0;
    while (bits < 20 && n < 100) begin
      @(negedge clk);
      n++;
      if (cmd_oe) bits++;
    end
    checks++;
    if (bits !== 20) begin
      errors++;
      $display("FAIL midsend_reach: got %0d bits expected 20", bits);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_oe, cmd_out_sd, bus.ACK_out, bus.REQ_out} !== 4'b0100 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL midsend_reset: got oe/out/ack/req=%b state=%0d expected 0100 0",
               {cmd_oe, cmd_out_sd, bus.ACK_out, bus.REQ_out}, state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
    test_response("after_reset", CMD8, TX_CMD8, 1'b1, R8_GOOD, 5, 54, RESP8, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_response("cmd8_good", CMD8, TX_CMD8, 1'b1, R8_GOOD, 5, 54, RESP8, 1'b0, 1'b0);
`ifdef CMD_CRC_CHECK_EN
    test_response("cmd8_badcrc", CMD8, TX_CMD8, 1'b1, R8_BADCRC, 5, 54, RESP8, 1'b1, 1'b0);
`else
    test_response("cmd8_badcrc", CMD8, TX_CMD8, 1'b1, R8_BADCRC, 5, 54, RESP8, 1'b0, 1'b0);
`endif
    test_response("cmd8_badend", CMD8, TX_CMD8, 1'b1, R8_BADEND, 5, 54, RESP8, 1'b1, 1'b0);
    test_response("cmd0_timeout", 38'h0, TX_CMD0, 1'b0, 48'h0, 0, 64, 38'h0, 1'b0, 1'b1);
    test_response("cmd8_badtx", CMD8, TX_CMD8, 1'b1, R8_BADTX, 3, 52, RESP8, 1'b1, 1'b0);
    test_response("start_first", CMD8, TX_CMD8, 1'b1, R8_GOOD, 0, 49, RESP8, 1'b0, 1'b0);
    test_response("start_last", CMD8, TX_CMD8, 1'b1, R8_GOOD, 63, 112, RESP8, 1'b0, 1'b0);
    test_handshake_stall();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
